// File: rtl/epu_dma_master.sv
// AXI4 block-copy initiator: each chunk is one read burst into a local buffer, then one write burst out of it.
// Optional EPU_DMA_AUTO_KICK_EN: after the last chunk, write 32'h1 to KICK_ADDR to start the EPU.
module epu_dma_master #(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                LEN_W     = 4,
    parameter int                MAX_BURST = 16,
    parameter logic [ADDR_W-1:0] KICK_ADDR = 32'h6000_8000
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src,
    input  logic [ADDR_W-1:0]   dst,
    input  logic [15:0]         nwords,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ID_W-1:0]     ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [LEN_W-1:0]    ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [ID_W-1:0]     RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [LEN_W-1:0]    AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [3:0]          dbg_state,
    output logic [ID_W-1:0]     dbg_rsp_id
);

    // Handshakes: a transfer happens on the rising CLK edge where VALID and READY are both high;
    // once VALID is raised, it and its payload stay stable until that edge.

    localparam int CNT_W = LEN_W + 1;
    localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [16:0] MAX17 = 17'(MAX_BURST);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_AR      = 4'd1,
        S_R       = 4'd2,
        S_AW      = 4'd3,
        S_W       = 4'd4,
        S_B       = 4'd5,
`ifdef EPU_DMA_AUTO_KICK_EN
        S_KICK_AW = 4'd6,
        S_KICK_W  = 4'd7,
        S_KICK_B  = 4'd8,
`endif
        S_DONE    = 4'd9
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [15:0]         remain_q;
    logic [CNT_W-1:0]    beats_q, idx_q;
    logic                err_q;
    logic [DATA_W-1:0]   data_buf_q [MAX_BURST];

    logic [16:0]         rd_room, wr_room, lim;
    logic [CNT_W-1:0]    beats_c;
    logic                r_exp_last, r_last_c, r_err_c;

    // Chunk size is limited by words left, buffer depth and the 4KB page of both addresses.
    always_comb begin
        rd_room = 17'd1024 - 17'(rd_addr_q[11:2]);
        wr_room = 17'd1024 - 17'(wr_addr_q[11:2]);
        lim     = {1'b0, remain_q};
        if (lim > MAX17)   lim = MAX17;
        if (lim > rd_room) lim = rd_room;
        if (lim > wr_room) lim = wr_room;
        beats_c = lim[CNT_W-1:0];
    end

    assign r_exp_last = (idx_q + CNT_W'(1)) == beats_q;
    assign r_last_c   = RLAST || r_exp_last;
    assign r_err_c    = (RRESP != 2'b00) || (RLAST != r_exp_last);

    always_comb begin
        state_d = state_q;
        ARADDR  = '0;
        ARLEN   = '0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        AWADDR  = '0;
        AWLEN   = '0;
        AWVALID = 1'b0;
        WDATA   = '0;
        WLAST   = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = (nwords == 16'd0) ? S_DONE : S_AR;
            S_AR: begin
                ARVALID = 1'b1;
                ARADDR  = rd_addr_q;
                ARLEN   = LEN_W'(beats_c - CNT_W'(1));
                if (ARREADY) state_d = S_R;
            end
            S_R: begin
                RREADY = 1'b1;
                // An errored chunk is drained but never written out.
                if (RVALID && r_last_c) state_d = (err_q || r_err_c) ? S_DONE : S_AW;
            end
            S_AW: begin
                AWVALID = 1'b1;
                AWADDR  = wr_addr_q;
                AWLEN   = LEN_W'(beats_q - CNT_W'(1));
                if (AWREADY) state_d = S_W;
            end
            S_W: begin
                WVALID = 1'b1;
                WDATA  = data_buf_q[idx_q[IDX_W-1:0]];
                WLAST  = (idx_q == beats_q - CNT_W'(1));
                if (WREADY && WLAST) state_d = S_B;
            end
            S_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    if (BRESP != 2'b00)                 state_d = S_DONE;
                    else if (remain_q != 16'(beats_q))  state_d = S_AR;
                    else begin
`ifdef EPU_DMA_AUTO_KICK_EN
                        state_d = S_KICK_AW;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef EPU_DMA_AUTO_KICK_EN
            S_KICK_AW: begin
                AWVALID = 1'b1;
                AWADDR  = KICK_ADDR;
                if (AWREADY) state_d = S_KICK_W;
            end
            S_KICK_W: begin
                WVALID = 1'b1;
                WDATA  = DATA_W'(1);
                WLAST  = 1'b1;
                if (WREADY) state_d = S_KICK_B;
            end
            S_KICK_B: begin
                BREADY = 1'b1;
                if (BVALID) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            remain_q  <= '0;
            beats_q   <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start) begin
                    rd_addr_q <= src;
                    wr_addr_q <= dst;
                    remain_q  <= nwords;
                    err_q     <= 1'b0;
                end
                S_AR: if (ARREADY) begin
                    beats_q <= beats_c;
                    idx_q   <= '0;
                end
                S_R: if (RVALID) begin
                    idx_q <= r_last_c ? '0 : idx_q + CNT_W'(1);
                    if (r_err_c) err_q <= 1'b1;
                end
                S_W: if (WREADY) idx_q <= WLAST ? '0 : idx_q + CNT_W'(1);
                S_B: if (BVALID) begin
                    rd_addr_q <= rd_addr_q + ADDR_W'({beats_q, 2'b00});
                    wr_addr_q <= wr_addr_q + ADDR_W'({beats_q, 2'b00});
                    remain_q  <= remain_q - 16'(beats_q);
                    if (BRESP != 2'b00) err_q <= 1'b1;
                end
`ifdef EPU_DMA_AUTO_KICK_EN
                S_KICK_B: if (BVALID && BRESP != 2'b00) err_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == S_R && RVALID && !r_err_c || state_q == S_R && RVALID)
            data_buf_q[idx_q[IDX_W-1:0]] <= RDATA;
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign ARID       = '0;
    assign ARSIZE     = 3'b010;
    assign ARBURST    = 2'b01;
    assign AWID       = '0;
    assign AWSIZE     = 3'b010;
    assign AWBURST    = 2'b01;
    assign WSTRB      = '1;
    assign dbg_state  = state_q;
    assign dbg_rsp_id = (state_q == S_R) ? RID : BID;

endmodule

// File: tb/tb_epu_dma_master.sv
// Directed bench for epu_dma_master: a small AXI slave model with a byte-addressed write memory,
// read data derived from address (~addr), and optional random READY/VALID back-pressure.
module tb_epu_dma_master;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [15:0] nwords = '0;
    logic        busy, done, err;
    logic [3:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  dbg_state, dbg_rsp_id;

    epu_dma_master dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .src(src), .dst(dst), .nwords(nwords),
        .busy(busy), .done(done), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .dbg_state(dbg_state), .dbg_rsp_id(dbg_rsp_id)
    );

`ifdef EPU_DMA_AUTO_KICK_EN
    localparam int KICK = 1;
`else
    localparam int KICK = 0;
`endif

    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_assert = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave model state and logs
    bit          bp = 0, b_err = 0, run_flag = 0;
    int          r_err_at = -1;
    bit          rd_active = 0, wr_active = 0, b_pending = 0;
    logic [31:0] rd_addr, wr_addr;
    int          rd_len, rd_beat, wr_len, wr_beat;
    int          rcnt, done_cnt, done_cyc, last_b_cyc, stab_err, wlast_err, w_early, busy_gap;
    logic [31:0] ar_addr_log[$], aw_addr_log[$];
    int          ar_len_log[$], aw_len_log[$];
    logic [31:0] wmem [logic [31:0]];
    bit          p_ar, p_aw, p_w;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_arlen, p_awlen;
    logic        p_wlast;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return ~a;
    endfunction

    initial begin
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0; RRESP = '0;
        BVALID = 0; BRESP = '0; RID = 4'h3; BID = 4'h5;
        forever begin
            @(negedge CLK);
            ARREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            AWREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            WREADY  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            RVALID  = rd_active && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            RDATA   = data_of(rd_addr + 32'(4 * rd_beat));
            RLAST   = rd_active && (rd_beat == rd_len);
            RRESP   = (rcnt == r_err_at) ? 2'b10 : 2'b00;
            BVALID  = b_pending && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            BRESP   = b_err ? 2'b10 : 2'b00;
            #1;
            if (!RSTn) begin
                rd_active = 0; wr_active = 0; b_pending = 0; p_ar = 0; p_aw = 0; p_w = 0;
                RVALID = 0; BVALID = 0;
                continue;
            end
            if (p_ar && (!ARVALID || ARADDR !== p_araddr || ARLEN !== p_arlen)) stab_err++;
            if (p_aw && (!AWVALID || AWADDR !== p_awaddr || AWLEN !== p_awlen)) stab_err++;
            if (p_w && (!WVALID || WDATA !== p_wdata || WLAST !== p_wlast)) stab_err++;
            p_ar = ARVALID && !ARREADY; p_araddr = ARADDR; p_arlen = ARLEN;
            p_aw = AWVALID && !AWREADY; p_awaddr = AWADDR; p_awlen = AWLEN;
            p_w  = WVALID && !WREADY;   p_wdata = WDATA;   p_wlast = WLAST;
            if (ARVALID && ARREADY) begin
                ar_addr_log.push_back(ARADDR); ar_len_log.push_back(int'(ARLEN));
                rd_active = 1; rd_addr = ARADDR; rd_len = int'(ARLEN); rd_beat = 0;
            end
            if (RVALID && RREADY) begin
                rcnt++;
                if (rd_beat == rd_len) rd_active = 0;
                else rd_beat++;
            end
            if (AWVALID && AWREADY) begin
                aw_addr_log.push_back(AWADDR); aw_len_log.push_back(int'(AWLEN));
                wr_active = 1; wr_addr = AWADDR; wr_len = int'(AWLEN); wr_beat = 0;
            end
            if (WVALID && WREADY) begin
                if (!wr_active) w_early++;
                wmem[wr_addr + 32'(4 * wr_beat)] = WDATA;
                if (WLAST !== (wr_beat == wr_len)) wlast_err++;
                if (wr_beat == wr_len) begin
                    wr_active = 0; b_pending = 1;
                end
                wr_beat++;
            end
            if (BVALID && BREADY) begin
                b_pending = 0; b_err = 0; last_b_cyc = cyc;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
            end
            if (run_flag && !busy && !done) busy_gap++;
        end
    end

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input bit track_busy, input int inj_at);
        bit timed_out;
        ar_addr_log.delete(); ar_len_log.delete(); aw_addr_log.delete(); aw_len_log.delete();
        wmem.delete();
        done_cnt = 0; rcnt = 0; stab_err = 0; wlast_err = 0; w_early = 0; busy_gap = 0;
        @(negedge CLK);
        src = s; dst = d; nwords = n; start = 1;
        @(negedge CLK);
        start = 0;
        run_flag = track_busy;
        timed_out = 1;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > 0) begin
                timed_out = 0;
                break;
            end
            if (i == inj_at) begin
                check("busy_at_restart", 32'(busy), 32'd1);
                src = 32'h2000_0000; dst = 32'h7000_0000; nwords = 16'd3; start = 1;
                @(posedge CLK); #1;
                start = 0;
            end
            @(negedge CLK); #2;
        end
        run_flag = 0;
        check("timeout", 32'(timed_out), 32'd0);
        repeat (4) @(negedge CLK);
        #2;
    endtask

    task automatic check_data(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a, v;
            a = d + 32'(4 * i);
            v = wmem.exists(a) ? wmem[a] : 32'hxxxx_xxxx;
            check($sformatf("%s_w%0d", tag, i), v, data_of(s + 32'(4 * i)));
        end
    endtask

    task automatic check_kick(input string tag, input int idx);
`ifdef EPU_DMA_AUTO_KICK_EN
        logic [31:0] v;
        check({tag, "_kick_addr"}, aw_addr_log[idx], 32'h6000_8000);
        check({tag, "_kick_len"}, 32'(aw_len_log[idx]), 32'd0);
        v = wmem.exists(32'h6000_8000) ? wmem[32'h6000_8000] : 32'hxxxx_xxxx;
        check({tag, "_kick_data"}, v, 32'h1);
`else
        check({tag, "_no_kick"}, 32'(wmem.exists(32'h6000_8000)), 32'd0);
        check({tag, "_aw_idx"}, 32'(aw_addr_log.size()), 32'(idx));
`endif
    endtask

    initial begin
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valids", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
        check("rst_araddr", ARADDR, 32'd0);
        check("rst_arlen", 32'(ARLEN), 32'd0);
        check("rst_awaddr", AWADDR, 32'd0);
        check("rst_awlen", 32'(AWLEN), 32'd0);
        repeat (2) @(negedge CLK);
        RSTn = 1;
        repeat (2) @(negedge CLK);
        #2;
        check("idle_state", 32'(dbg_state), 32'd0);
        check("arsize", 32'(ARSIZE), 32'd2);
        check("wstrb", 32'(WSTRB), 32'hF);

        // 1: single 4-word burst, zero-wait slave
        run_copy(32'h1000_0000, 32'h6000_0000, 16'd4, 1, -1);
        check("t1_ar_n", 32'(ar_addr_log.size()), 32'd1);
        check("t1_ar_addr", ar_addr_log[0], 32'h1000_0000);
        check("t1_ar_len", 32'(ar_len_log[0]), 32'd3);
        check("t1_aw_n", 32'(aw_addr_log.size()), 32'(1 + KICK));
        check("t1_aw_addr", aw_addr_log[0], 32'h6000_0000);
        check("t1_aw_len", 32'(aw_len_log[0]), 32'd3);
        check_data("t1", 32'h1000_0000, 32'h6000_0000, 4);
        check("t1_wlast", 32'(wlast_err), 32'd0);
        check("t1_done_n", 32'(done_cnt), 32'd1);
        check("t1_done_lat", 32'(done_cyc - last_b_cyc), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy_gap", 32'(busy_gap), 32'd0);
        check_kick("t1", 1);

        // 2: 40 words -> 16/16/8
        run_copy(32'h1000_0100, 32'h6000_0400, 16'd40, 1, -1);
        check("t2_ar_n", 32'(ar_addr_log.size()), 32'd3);
        check("t2_ar0", ar_addr_log[0], 32'h1000_0100);
        check("t2_ar1", ar_addr_log[1], 32'h1000_0140);
        check("t2_ar2", ar_addr_log[2], 32'h1000_0180);
        check("t2_len0", 32'(ar_len_log[0]), 32'd15);
        check("t2_len1", 32'(ar_len_log[1]), 32'd15);
        check("t2_len2", 32'(ar_len_log[2]), 32'd7);
        check("t2_aw2", aw_addr_log[2], 32'h6000_0480);
        check("t2_awlen2", 32'(aw_len_log[2]), 32'd7);
        check_data("t2", 32'h1000_0100, 32'h6000_0400, 40);
        check("t2_done_n", 32'(done_cnt), 32'd1);
        check("t2_busy_gap", 32'(busy_gap), 32'd0);
        check("t2_wlast", 32'(wlast_err), 32'd0);

        // 3: 4KB split of the read side
        run_copy(32'h1000_0FF8, 32'h6000_2000, 16'd6, 1, -1);
        check("t3_ar_n", 32'(ar_addr_log.size()), 32'd2);
        check("t3_len0", 32'(ar_len_log[0]), 32'd1);
        check("t3_ar1", ar_addr_log[1], 32'h1000_1000);
        check("t3_len1", 32'(ar_len_log[1]), 32'd3);
        check("t3_aw1", aw_addr_log[1], 32'h6000_2008);
        check_data("t3", 32'h1000_0FF8, 32'h6000_2000, 6);

        // 4: RRESP error on a read beat
        r_err_at = 2;
        run_copy(32'h1000_3000, 32'h6000_3000, 16'd4, 1, -1);
        r_err_at = -1;
        check("t4_rbeats", 32'(rcnt), 32'd4);
        check("t4_err", 32'(err), 32'd1);
        check("t4_done_n", 32'(done_cnt), 32'd1);
        check("t4_ar_n", 32'(ar_addr_log.size()), 32'd1);
        check("t4_aw_n", 32'(aw_addr_log.size()), 32'd0);

        // BRESP error on the first chunk of a two-chunk copy
        b_err = 1;
        run_copy(32'h1000_4000, 32'h6000_4000, 16'd20, 1, -1);
        check("tb_ar_n", 32'(ar_addr_log.size()), 32'd1);
        check("tb_aw_n", 32'(aw_addr_log.size()), 32'd1);
        check("tb_err", 32'(err), 32'd1);
        check("tb_done_n", 32'(done_cnt), 32'd1);

        // Zero-length copy; also clears the sticky err
        run_copy(32'h1000_5000, 32'h6000_5000, 16'd0, 0, -1);
        check("tz_done_n", 32'(done_cnt), 32'd1);
        check("tz_ar_n", 32'(ar_addr_log.size()), 32'd0);
        check("tz_aw_n", 32'(aw_addr_log.size()), 32'd0);
        check("tz_err", 32'(err), 32'd0);

        // 5: random back-pressure plus a start pulse while busy
        bp = 1;
        run_copy(32'h1000_6000, 32'h6000_6000, 16'd24, 1, 10);
        bp = 0;
        check("t5_ar_n", 32'(ar_addr_log.size()), 32'd2);
        check("t5_len0", 32'(ar_len_log[0]), 32'd15);
        check("t5_len1", 32'(ar_len_log[1]), 32'd7);
        check("t5_ar1", ar_addr_log[1], 32'h1000_6040);
        check_data("t5", 32'h1000_6000, 32'h6000_6000, 24);
        check("t5_stable", 32'(stab_err), 32'd0);
        check("t5_wlast", 32'(wlast_err), 32'd0);
        check("t5_w_early", 32'(w_early), 32'd0);
        check("t5_done_n", 32'(done_cnt), 32'd1);
        check("t5_err", 32'(err), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        check_kick("t5", 2);

        // 6: kick behaviour on a 2-word copy
        run_copy(32'h1000_7000, 32'h6000_7000, 16'd2, 1, -1);
        check("t6_aw_n", 32'(aw_addr_log.size()), 32'(1 + KICK));
        check_data("t6", 32'h1000_7000, 32'h6000_7000, 2);
        check_kick("t6", 1);

        // Reset asserted mid-burst
        @(negedge CLK);
        src = 32'h1000_8000; dst = 32'h6000_8100; nwords = 16'd40; start = 1;
        @(negedge CLK);
        start = 0;
        repeat (8) @(negedge CLK);
        #3;
        RSTn = 0;
        #1;
        check("mrst_valids", {29'd0, ARVALID, AWVALID, WVALID}, 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge CLK);
        RSTn = 1;
        repeat (3) @(negedge CLK);
        #2;
        check("mrst_idle", 32'(dbg_state), 32'd0);
        check("mrst_quiet", {29'd0, ARVALID, AWVALID, WVALID}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
